// File: rtl/tmds_rx_pkg.sv
// Shared TMDS receive definitions: control tokens, alignment FSM states and
// the token classifier used by the word aligner.
package tmds_rx_pkg;

    localparam logic [9:0] TMDS_CTL0 = 10'h354;
    localparam logic [9:0] TMDS_CTL1 = 10'h0AB;
    localparam logic [9:0] TMDS_CTL2 = 10'h154;
    localparam logic [9:0] TMDS_CTL3 = 10'h2AB;

    typedef enum logic [2:0] {
        HUNT,
        SLIP,
        SETTLE,
        CONFIRM,
        LOCKED
    } align_state_t;

    function automatic logic is_ctl_token(input logic [9:0] w);
        return (w == TMDS_CTL0) || (w == TMDS_CTL1) ||
               (w == TMDS_CTL2) || (w == TMDS_CTL3);
    endfunction

endpackage

// File: rtl/gearbox_4to10.sv
// 4-bit to 10-bit repacker with a one-bit slip; the buffer keeps the oldest
// bit at position 0 and never holds more than 9 bits between cycles.
module gearbox_4to10 (
    input  logic       clkdiv4,
    input  logic       rxrst,
    input  logic [3:0] rxdata,
    input  logic       slip,
    output logic [9:0] word,
    output logic       valid
);

    logic [12:0] bit_buf_reg, bit_buf_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [9:0]  word_reg, word_next;
    logic        valid_reg, valid_next;
    logic [12:0] raw;
    logic [12:0] comb;
    logic [4:0]  n;

    always_comb begin
        // Bits above cnt in the buffer are always zero, so OR-merging is safe.
        raw          = ({9'd0, rxdata} << cnt_reg) | bit_buf_reg;
        comb         = slip ? (raw >> 1) : raw;
        n            = {1'b0, cnt_reg} + (slip ? 5'd3 : 5'd4);
        word_next    = word_reg;
        valid_next   = 1'b0;
        bit_buf_next = comb;
        cnt_next     = n[3:0];
        if (n >= 5'd10) begin
            word_next    = comb[9:0];
            valid_next   = 1'b1;
            bit_buf_next = comb >> 10;
            cnt_next     = 4'(n - 5'd10);
        end
    end

    always_ff @(posedge clkdiv4) begin
        if (rxrst) begin
            bit_buf_reg <= '0;
            cnt_reg     <= '0;
            word_reg    <= '0;
            valid_reg   <= 1'b0;
        end else begin
            bit_buf_reg <= bit_buf_next;
            cnt_reg     <= cnt_next;
            word_reg    <= word_next;
            valid_reg   <= valid_next;
        end
    end

    assign word  = word_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/iserdese3_4to10_align.sv
// TMDS character aligner: repacks ISERDESE3 4-bit words into 10-bit characters
// and bitslips until a run of control tokens marks the character boundary.
module iserdese3_4to10_align
    import tmds_rx_pkg::*;
#(
    parameter int SEARCH_WORDS = 4096,
    parameter int LOCK_TOKENS  = 8,
    parameter int LOSS_WORDS   = 8192,
    parameter int SETTLE_WORDS = 2
) (
    input  logic       clkdiv4,
    input  logic       rxrst,
    input  logic [3:0] rxdata,
    output logic [9:0] rx_word,
    output logic       rx_valid,
    output logic       locked,
    output logic [3:0] slip_cnt
);

    localparam int SW_W = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
    localparam int TK_W = (LOCK_TOKENS  > 1) ? $clog2(LOCK_TOKENS)  : 1;
    localparam int LW_W = (LOSS_WORDS   > 1) ? $clog2(LOSS_WORDS)   : 1;
    localparam int ST_W = (SETTLE_WORDS > 1) ? $clog2(SETTLE_WORDS) : 1;

    align_state_t    state_reg, state_next;
    logic [SW_W-1:0] search_cnt_reg, search_cnt_next;
    logic [TK_W-1:0] tok_cnt_reg, tok_cnt_next;
    logic [LW_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic [ST_W-1:0] settle_cnt_reg, settle_cnt_next;
    logic [3:0]      slip_cnt_reg, slip_cnt_next;
    logic            locked_reg;
    logic            tok;

    gearbox_4to10 u_gearbox (
        .clkdiv4 (clkdiv4),
        .rxrst   (rxrst),
        .rxdata  (rxdata),
        .slip    (state_reg == SLIP),
        .word    (rx_word),
        .valid   (rx_valid)
    );

    assign tok = is_ctl_token(rx_word);

    always_comb begin
        state_next      = state_reg;
        search_cnt_next = search_cnt_reg;
        tok_cnt_next    = tok_cnt_reg;
        idle_cnt_next   = idle_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        slip_cnt_next   = slip_cnt_reg;
        case (state_reg)
            HUNT: if (rx_valid) begin
                if (tok) begin
                    state_next   = CONFIRM;
                    tok_cnt_next = TK_W'(1);
                end else if (search_cnt_reg == SW_W'(SEARCH_WORDS - 1)) begin
                    state_next = SLIP;
                end else begin
                    search_cnt_next = search_cnt_reg + SW_W'(1);
                end
            end
            SLIP: begin
                // Words that land while slipping are ignored; SETTLE flushes the rest.
                state_next      = SETTLE;
                settle_cnt_next = '0;
                slip_cnt_next   = (slip_cnt_reg == 4'd9) ? 4'd0 : slip_cnt_reg + 4'd1;
            end
            SETTLE: if (rx_valid) begin
                if (settle_cnt_reg == ST_W'(SETTLE_WORDS - 1)) begin
                    state_next      = HUNT;
                    search_cnt_next = '0;
                end else begin
                    settle_cnt_next = settle_cnt_reg + ST_W'(1);
                end
            end
            CONFIRM: if (rx_valid) begin
                if (!tok) begin
                    state_next      = HUNT;
                    search_cnt_next = '0;
                end else if (tok_cnt_reg == TK_W'(LOCK_TOKENS - 1)) begin
                    state_next    = LOCKED;
                    idle_cnt_next = '0;
                end else begin
                    tok_cnt_next = tok_cnt_reg + TK_W'(1);
                end
            end
            LOCKED: if (rx_valid) begin
                if (tok) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_reg == LW_W'(LOSS_WORDS - 1)) begin
                    state_next      = HUNT;
                    search_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg + LW_W'(1);
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clkdiv4) begin
        if (rxrst) begin
            state_reg      <= HUNT;
            search_cnt_reg <= '0;
            tok_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
            slip_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            search_cnt_reg <= search_cnt_next;
            tok_cnt_reg    <= tok_cnt_next;
            idle_cnt_reg   <= idle_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            slip_cnt_reg   <= slip_cnt_next;
            locked_reg     <= (state_next == LOCKED);
        end
    end

    assign locked   = locked_reg;
    assign slip_cnt = slip_cnt_reg;

endmodule

// File: tb/tb_iserdese3_4to10_align.sv
// Bench for the TMDS aligner: a serial bit-queue reference model is compared
// against the DUT every cycle, plus literal checks for each scenario.
module tb_iserdese3_4to10_align;

    localparam int SW = 16;
    localparam int LT = 4;
    localparam int LW = 64;
    localparam int SS = 2;

    logic       clkdiv4 = 1'b0;
    logic       rxrst   = 1'b1;
    logic [3:0] rxdata  = 4'd0;
    logic [9:0] rx_word;
    logic       rx_valid;
    logic       locked;
    logic [3:0] slip_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clkdiv4 = ~clkdiv4;

    iserdese3_4to10_align #(
        .SEARCH_WORDS (SW),
        .LOCK_TOKENS  (LT),
        .LOSS_WORDS   (LW),
        .SETTLE_WORDS (SS)
    ) dut (
        .clkdiv4  (clkdiv4),
        .rxrst    (rxrst),
        .rxdata   (rxdata),
        .rx_word  (rx_word),
        .rx_valid (rx_valid),
        .locked   (locked),
        .slip_cnt (slip_cnt)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    function automatic bit is_tok(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // Reference model: received bits go into a FIFO; every 10 bits make a word.
    // mode: 0 hunt, 1 slip, 2 settle, 3 confirm, 4 locked.
    bit         mq[$];
    logic [9:0] m_word  = '0;
    bit         m_valid = 1'b0;
    int         m_mode  = 0;
    int         m_slips = 0;
    int         m_words = 0;

    always @(posedge clkdiv4) begin : model
        bit         slip_now;
        bit         t;
        logic [9:0] w;
        if (rxrst) begin
            mq.delete();
            m_word  = '0;
            m_valid = 1'b0;
            m_mode  = 0;
            m_slips = 0;
            m_words = 0;
        end else begin
            slip_now = (m_mode == 1);
            t = is_tok(m_word);
            if (m_mode == 1) begin
                m_slips = (m_slips + 1) % 10;
                m_mode  = 2;
                m_words = 0;
            end else if (m_valid) begin
                case (m_mode)
                    0: if (t) begin m_mode = 3; m_words = 1; end
                       else begin
                           m_words++;
                           if (m_words == SW) m_mode = 1;
                       end
                    2: begin
                           m_words++;
                           if (m_words == SS) begin m_mode = 0; m_words = 0; end
                       end
                    3: if (!t) begin m_mode = 0; m_words = 0; end
                       else begin
                           m_words++;
                           if (m_words == LT) begin m_mode = 4; m_words = 0; end
                       end
                    default: if (t) m_words = 0;
                       else begin
                           m_words++;
                           if (m_words == LW) begin m_mode = 0; m_words = 0; end
                       end
                endcase
            end
            for (int i = 0; i < 4; i++) mq.push_back(rxdata[i]);
            if (slip_now) void'(mq.pop_front());
            if (mq.size() >= 10) begin
                for (int i = 0; i < 10; i++) w[i] = mq.pop_front();
                m_word  = w;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clkdiv4) begin
        check("rx_valid", int'(rx_valid), int'(m_valid));
        check("rx_word", int'(rx_word), int'(m_word));
        check("locked", int'(locked), (m_mode == 4) ? 1 : 0);
        check("slip_cnt", int'(slip_cnt), m_slips);
    end

    // Stimulus source: scheduled words first, then a fill word or token-free noise.
    bit         gq[$];
    logic [9:0] sched[$];
    logic [9:0] fill_word  = 10'h354;
    bit         fill_noise = 1'b0;

    task automatic refill();
        while (gq.size() < 4) begin
            logic [9:0] w;
            if (sched.size() > 0) w = sched.pop_front();
            else if (fill_noise) begin
                do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
            end else w = fill_word;
            for (int i = 0; i < 10; i++) gq.push_back(w[i]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            refill();
            for (int i = 0; i < 4; i++) rxdata[i] = gq.pop_front();
            @(negedge clkdiv4);
        end
    endtask

    task automatic do_reset(input int cyc);
        rxrst  = 1'b1;
        rxdata = 4'($urandom);
        repeat (cyc) @(negedge clkdiv4);
        rxrst = 1'b0;
        gq.delete();
        sched.delete();
    endtask

    task automatic push_junk(input int k);
        for (int i = 0; i < k; i++) gq.push_back(1'($urandom));
    endtask

    task automatic wait_locked(input bit exp, input int budget, input string name);
        int i = 0;
        while (locked !== exp && i < budget) begin
            tick(1);
            i++;
        end
        check(name, int'(locked), int'(exp));
    endtask

    initial begin
        int v;
        int drops;
        int i;

        // 1: aligned token stream
        fill_noise = 1'b0;
        fill_word  = 10'h354;
        do_reset(2);
        tick(1); check("s1_valid_c1", int'(rx_valid), 0);
        tick(1); check("s1_valid_c2", int'(rx_valid), 0);
        tick(1); check("s1_valid_c3", int'(rx_valid), 1);
        check("s1_word_c3", int'(rx_word), 'h354);
        v = 0;
        repeat (50) begin tick(1); v += int'(rx_valid); end
        check("s1_rate", v, 20);
        check("s1_locked", int'(locked), 1);
        check("s1_slips", int'(slip_cnt), 0);

        // 2: three junk bits need three slips
        do_reset(1);
        push_junk(3);
        wait_locked(1'b1, 600, "s2_lock");
        check("s2_slips", int'(slip_cnt), 3);
        repeat (40) begin
            tick(1);
            if (rx_valid) check("s2_word", int'(rx_word), 'h354);
        end

        // 3: nine slips, then noise forces a tenth slip that wraps the count
        do_reset(1);
        push_junk(9);
        wait_locked(1'b1, 1500, "s3_lock");
        check("s3_slips", int'(slip_cnt), 9);
        fill_noise = 1'b1;
        i = 0;
        while (slip_cnt != 4'd0 && i < 500) begin tick(1); i++; end
        check("s3_wrap", int'(slip_cnt), 0);
        check("s3_nolock", int'(locked), 0);
        fill_noise = 1'b0;

        // 4: 63 idle words then a token keeps lock; 64 drops it
        do_reset(1);
        wait_locked(1'b1, 100, "s4_lock");
        for (int k = 0; k < LW - 1; k++) sched.push_back(10'h1F0);
        sched.push_back(10'h2AB);
        drops = 0;
        repeat (200) begin tick(1); if (!locked) drops++; end
        check("s4_keep", drops, 0);
        for (int k = 0; k < LW; k++) sched.push_back(10'h1F0);
        wait_locked(1'b0, 250, "s4_drop");
        wait_locked(1'b1, 100, "s4_relock");

        // 5: three tokens then a non-token aborts CONFIRM without a slip
        do_reset(1);
        fill_word = 10'h1F0;
        sched.push_back(10'h354);
        sched.push_back(10'h354);
        sched.push_back(10'h354);
        sched.push_back(10'h1F0);
        tick(25);
        check("s5_locked", int'(locked), 0);
        check("s5_slips", int'(slip_cnt), 0);
        fill_word = 10'h354;
        wait_locked(1'b1, 100, "s5_relock");
        check("s5_slips_after", int'(slip_cnt), 0);

        // 6: one-cycle reset while locked with a non-zero slip count
        do_reset(1);
        push_junk(3);
        wait_locked(1'b1, 600, "s6_lock");
        check("s6_slips_pre", int'(slip_cnt), 3);
        do_reset(1);
        check("s6_locked", int'(locked), 0);
        check("s6_valid", int'(rx_valid), 0);
        check("s6_word", int'(rx_word), 0);
        check("s6_slips", int'(slip_cnt), 0);
        tick(3);
        check("s6_valid_c3", int'(rx_valid), 1);
        check("s6_word_c3", int'(rx_word), 'h354);
        wait_locked(1'b1, 100, "s6_relock");
        check("s6_slips_relock", int'(slip_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
